// File: rtl/razor_recovery_ctrl_if.sv
// Razor error flags in, stall/replay/DVS requests out; Log_clear and
// Err_stage_log exist only when RAZOR_ERRLOG_EN is defined.
interface razor_recovery_ctrl_if #(
  parameter int NSTAGE = 4,
  parameter int CNT_W  = 16
);
  logic [NSTAGE-1:0] Error_in;
  logic              Enable;
  logic              Stall;
  logic              Replay;
  logic [CNT_W-1:0]  Err_count;
  logic              Vdd_up;
  logic              Vdd_down;
  logic              Busy;
`ifdef RAZOR_ERRLOG_EN
  logic [NSTAGE-1:0] Err_stage_log;
  logic              Log_clear;
`endif

  modport master (
    output Error_in,
    output Enable,
`ifdef RAZOR_ERRLOG_EN
    output Log_clear,
    input  Err_stage_log,
`endif
    input  Stall,
    input  Replay,
    input  Err_count,
    input  Vdd_up,
    input  Vdd_down,
    input  Busy
  );

  modport slave (
    input  Error_in,
    input  Enable,
`ifdef RAZOR_ERRLOG_EN
    input  Log_clear,
    output Err_stage_log,
`endif
    output Stall,
    output Replay,
    output Err_count,
    output Vdd_up,
    output Vdd_down,
    output Busy
  );
endinterface

// File: rtl/razor_recovery_ctrl.sv
// Razor timing-error recovery: stall + one-cycle replay, error statistics and
// windowed Vdd up/down requests. Optional sticky stage log: RAZOR_ERRLOG_EN.
module razor_recovery_ctrl #(
  parameter int NSTAGE    = 4,
  parameter int STALL_CYC = 1,
  parameter int WIN_LOG2  = 8,
  parameter int ERR_HI    = 4,
  parameter int CNT_W     = 16
) (
  input logic                  Clock,
  input logic                  Reset,
  razor_recovery_ctrl_if.slave bus
);

  localparam int SCW  = (STALL_CYC > 1) ? $clog2(STALL_CYC) : 1;
  localparam int EW_W = $clog2(ERR_HI + 1);

  typedef enum logic [1:0] {IDLE, RUN, STALL, REPLAY} state_t;

  state_t              state;
  logic [SCW-1:0]      stall_cnt;
  logic [WIN_LOG2-1:0] cyc;
  logic [EW_W-1:0]     ew;
  logic                det;
  logic                wrap;

  // Errors only count in RUN; anything seen during STALL/REPLAY is the echo
  // of the error being recovered.
  assign det  = (state == RUN) && (|bus.Error_in);
  assign wrap = (state != IDLE) && (cyc == '1);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      stall_cnt     <= '0;
      cyc           <= '0;
      ew            <= '0;
      bus.Stall     <= 1'b0;
      bus.Replay    <= 1'b0;
      bus.Busy      <= 1'b0;
      bus.Err_count <= '0;
      bus.Vdd_up    <= 1'b0;
      bus.Vdd_down  <= 1'b0;
`ifdef RAZOR_ERRLOG_EN
      bus.Err_stage_log <= '0;
`endif
    end else begin
      bus.Vdd_up   <= 1'b0;
      bus.Vdd_down <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.Enable) state <= RUN;
        end
        RUN: begin
          if (det) begin
            state     <= STALL;
            stall_cnt <= SCW'(STALL_CYC - 1);
            bus.Stall <= 1'b1;
            bus.Busy  <= 1'b1;
          end else if (!bus.Enable) begin
            state <= IDLE;
          end
        end
        STALL: begin
          if (stall_cnt == '0) begin
            state      <= REPLAY;
            bus.Replay <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt - SCW'(1);
          end
        end
        REPLAY: begin
          // Enable is only honoured once the replay has completed
          state      <= bus.Enable ? RUN : IDLE;
          bus.Stall  <= 1'b0;
          bus.Busy   <= 1'b0;
          bus.Replay <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (det && (bus.Err_count != '1))
        bus.Err_count <= bus.Err_count + CNT_W'(1);

      if (state != IDLE)
        cyc <= cyc + WIN_LOG2'(1);

      // A detection on the wrap edge belongs to the new window.
      if (wrap) begin
        bus.Vdd_up   <= (ew >= EW_W'(ERR_HI));
        bus.Vdd_down <= (ew == '0);
        ew           <= det ? EW_W'(1) : '0;
      end else if (det && (ew != EW_W'(ERR_HI))) begin
        ew <= ew + EW_W'(1);
      end

`ifdef RAZOR_ERRLOG_EN
      if (det)
        bus.Err_stage_log <= (bus.Log_clear ? '0 : bus.Err_stage_log) | bus.Error_in;
      else if (bus.Log_clear)
        bus.Err_stage_log <= '0;
`endif
    end
  end

endmodule
